// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC/alarm command codes, time field widths and alarm state type
package rtc_pkg;

  localparam int HOURS_W = 5;
  localparam int MIN_W   = 6;
  localparam int SEC_W   = 6;
  localparam int MS_W    = 10;

  // Alarm commands; every other code on the shared bus is owned by the RTC.
  localparam logic [2:0] CMD_ALARM_CTRL        = 3'b000;
  localparam logic [2:0] CMD_SET_ALARM_MINUTES = 3'b001;
  localparam logic [2:0] CMD_SET_ALARM_HOURS   = 3'b100;
  localparam logic [2:0] CMD_RTC_SET_HOURS     = 3'b010;
  localparam logic [2:0] CMD_RTC_SET_MINUTES   = 3'b011;
  localparam logic [2:0] CMD_RTC_SET_SECONDS   = 3'b101;
  localparam logic [2:0] CMD_RTC_CTRL          = 3'b110;
  localparam logic [2:0] CMD_RTC_RESERVED      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RINGING,
    ST_SNOOZE
  } alarm_state_e;

endpackage

// File: rtl/rtc_time_add_min.sv
// rtl/rtc_time_add_min.sv - combinational HH:MM + ADD_MIN minutes with hour and day wrap
module rtc_time_add_min
  import rtc_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [HOURS_W-1:0] hours_i,
  input  logic [MIN_W-1:0]   minutes_i,
  output logic [HOURS_W-1:0] hours_o,
  output logic [MIN_W-1:0]   minutes_o
);

  logic [MIN_W:0]   min_sum;
  logic [HOURS_W-1:0] hours_inc;

  always_comb begin
    min_sum   = {1'b0, minutes_i} + (MIN_W+1)'(ADD_MIN);
    hours_inc = (hours_i == HOURS_W'(23)) ? '0 : hours_i + 1'b1;
    if (min_sum >= (MIN_W+1)'(60)) begin
      minutes_o = MIN_W'(min_sum - (MIN_W+1)'(60));
      hours_o   = hours_inc;
    end else begin
      minutes_o = min_sum[MIN_W-1:0];
      hours_o   = hours_i;
    end
  end

endmodule

// File: rtl/rtc_alarm.sv
// rtl/rtc_alarm.sv - daily HH:MM alarm with ack, snooze and ring timeout on the shared RTC cmd bus
// Optional snooze limit enabled by defining RTC_ALARM_SNOOZE_LIMIT_EN.
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               cmd_valid_i,
  input  logic [2:0]         cmd_type_i,
  input  logic [9:0]         cmd_data_i,
  input  logic [HOURS_W-1:0] hours_i,
  input  logic [MIN_W-1:0]   minutes_i,
  input  logic [SEC_W-1:0]   seconds_i,
  input  logic [MS_W-1:0]    milliseconds_i,
  input  logic               ack_i,
  input  logic               snooze_i,
  output logic               alarm_o,
  output logic               armed_o,
  output logic [HOURS_W-1:0] alarm_hours_o,
  output logic [MIN_W-1:0]   alarm_minutes_o
);

  alarm_state_e       state_q, state_d;
  logic               cmd_valid_q, cmd_arm_q;
  logic [2:0]         cmd_type_q;
  logic [MIN_W-1:0]   cmd_val_q;
  logic [HOURS_W-1:0] alarm_hours_q, snz_hours_q, snz_hours_d;
  logic [MIN_W-1:0]   alarm_minutes_q, snz_minutes_q, snz_minutes_d;
  logic [7:0]         timeout_q;
  logic [SEC_W-1:0]   sec_prev_q;
  logic               alarm_q;
  logic               do_disarm, do_arm, at_zero, alarm_match, snooze_match;
  logic               timed_out, sec_edge, snooze_ok, enter_ring, enter_snooze;
  logic [HOURS_W-1:0] cmd_hours;
  logic               unused_ok;

  // Payload hours live in [9:5], which is the top of the captured [9:4] minutes field.
  assign cmd_hours    = cmd_val_q[MIN_W-1:1];
  assign do_disarm    = cmd_valid_q && (cmd_type_q == CMD_ALARM_CTRL) && !cmd_arm_q;
  assign do_arm       = cmd_valid_q && (cmd_type_q == CMD_ALARM_CTRL) && cmd_arm_q;
  assign at_zero      = (seconds_i == '0) && (milliseconds_i == '0);
  assign alarm_match  = at_zero && (hours_i == alarm_hours_q) && (minutes_i == alarm_minutes_q);
  assign snooze_match = at_zero && (hours_i == snz_hours_q) && (minutes_i == snz_minutes_q);
  assign timed_out    = (timeout_q == 8'(RING_TIMEOUT_S));
  assign sec_edge     = (seconds_i != sec_prev_q);
  assign enter_ring   = (state_q != ST_RINGING) && (state_d == ST_RINGING);
  assign enter_snooze = (state_q == ST_RINGING) && (state_d == ST_SNOOZE);
  assign unused_ok    = ^{cmd_data_i[3:1], MAX_SNOOZE != 0};

  rtc_time_add_min #(.ADD_MIN(SNOOZE_MIN)) u_snooze_add (
    .hours_i   (hours_i),
    .minutes_i (minutes_i),
    .hours_o   (snz_hours_d),
    .minutes_o (snz_minutes_d)
  );

`ifdef RTC_ALARM_SNOOZE_LIMIT_EN
  logic [3:0] snz_cnt_q;

  assign snooze_ok = (snz_cnt_q != 4'(MAX_SNOOZE));

  // Every exit to ARMED or IDLE is an ack, a timeout or a disarm.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      snz_cnt_q <= '0;
    end else if ((state_d == ST_ARMED) || (state_d == ST_IDLE)) begin
      snz_cnt_q <= '0;
    end else if (enter_snooze) begin
      snz_cnt_q <= snz_cnt_q + 4'd1;
    end
  end
`else
  assign snooze_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    if (do_disarm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (do_arm) state_d = ST_ARMED;
        ST_ARMED:   if (alarm_match) state_d = ST_RINGING;
        ST_RINGING: begin
          if (ack_i)         state_d = ST_ARMED;
          else if (snooze_i) state_d = snooze_ok ? ST_SNOOZE : ST_ARMED;
          else if (timed_out) state_d = ST_ARMED;
        end
        ST_SNOOZE: begin
          if (ack_i)             state_d = ST_ARMED;
          else if (snooze_match) state_d = ST_RINGING;
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q         <= ST_IDLE;
      cmd_valid_q     <= 1'b0;
      cmd_type_q      <= '0;
      cmd_val_q       <= '0;
      cmd_arm_q       <= 1'b0;
      alarm_hours_q   <= '0;
      alarm_minutes_q <= '0;
      snz_hours_q     <= '0;
      snz_minutes_q   <= '0;
      timeout_q       <= '0;
      sec_prev_q      <= '0;
      alarm_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_i;
      cmd_type_q  <= cmd_type_i;
      cmd_val_q   <= cmd_data_i[9:4];
      cmd_arm_q   <= cmd_data_i[0];
      sec_prev_q  <= seconds_i;
      alarm_q     <= (state_d == ST_RINGING);
      if (cmd_valid_q && (cmd_type_q == CMD_SET_ALARM_HOURS) && (cmd_hours <= HOURS_W'(23)))
        alarm_hours_q <= cmd_hours;
      if (cmd_valid_q && (cmd_type_q == CMD_SET_ALARM_MINUTES) && (cmd_val_q <= MIN_W'(59)))
        alarm_minutes_q <= cmd_val_q;
      if (enter_snooze) begin
        snz_hours_q   <= snz_hours_d;
        snz_minutes_q <= snz_minutes_d;
      end
      if (enter_ring)
        timeout_q <= '0;
      else if ((state_q == ST_RINGING) && sec_edge)
        timeout_q <= timeout_q + 8'd1;
    end
  end

  assign alarm_o         = alarm_q;
  assign armed_o         = (state_q != ST_IDLE);
  assign alarm_hours_o   = alarm_hours_q;
  assign alarm_minutes_o = alarm_minutes_q;

endmodule

// File: tb/tb_rtc_alarm.sv
// tb/tb_rtc_alarm.sv - randomized and directed bench for rtc_alarm against a minute-of-day model
// Define RTC_ALARM_SNOOZE_LIMIT_EN for both bench and RTL to exercise the snooze limit.
module tb_rtc_alarm;

  localparam int RING_TIMEOUT_S = 60;
  localparam int SNOOZE_MIN     = 5;
  localparam int MAX_SNOOZE     = 3;
  localparam int P_OFF = 0, P_WAIT = 1, P_RING = 2, P_SNOOZED = 3;

  logic       clk = 1'b0;
  logic       arst;
  logic       cmd_valid;
  logic [2:0] cmd_type;
  logic [9:0] cmd_data;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic [9:0] ms;
  logic       ack, snz;
  logic       alarm, armed;
  logic [4:0] ahr;
  logic [5:0] amin;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: alarm and snooze targets kept as minute-of-day values.
  int m_phase, m_ah, m_am, m_snz_tod, m_secs_rung, m_prev_sec, m_snoozes;
  int p_valid, p_type, p_data;
  int limit_on;

  always #5 clk = ~clk;

  rtc_alarm #(
    .RING_TIMEOUT_S (RING_TIMEOUT_S),
    .SNOOZE_MIN     (SNOOZE_MIN),
    .MAX_SNOOZE     (MAX_SNOOZE)
  ) dut (
    .clk_i           (clk),
    .arst_i          (arst),
    .cmd_valid_i     (cmd_valid),
    .cmd_type_i      (cmd_type),
    .cmd_data_i      (cmd_data),
    .hours_i         (hh),
    .minutes_i       (mm),
    .seconds_i       (ss),
    .milliseconds_i  (ms),
    .ack_i           (ack),
    .snooze_i        (snz),
    .alarm_o         (alarm),
    .armed_o         (armed),
    .alarm_hours_o   (ahr),
    .alarm_minutes_o (amin)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_OFF; m_ah = 0; m_am = 0; m_snz_tod = 0;
    m_secs_rung = 0; m_prev_sec = 0; m_snoozes = 0;
    p_valid = 0; p_type = 0; p_data = 0;
  endtask

  task automatic model_step();
    int tod, nxt;
    bit zero, sec_chg, disarm, arm;
    tod     = int'(hh) * 60 + int'(mm);
    zero    = (ss == 6'd0) && (ms == 10'd0);
    sec_chg = (int'(ss) != m_prev_sec);
    disarm  = (p_valid != 0) && (p_type == 0) && ((p_data & 1) == 0);
    arm     = (p_valid != 0) && (p_type == 0) && ((p_data & 1) == 1);
    nxt = m_phase;
    if (disarm) begin
      nxt = P_OFF; m_snoozes = 0;
    end else begin
      case (m_phase)
        P_OFF:  if (arm) nxt = P_WAIT;
        P_WAIT: if (zero && tod == m_ah * 60 + m_am) begin nxt = P_RING; m_secs_rung = 0; end
        P_RING: begin
          if (ack) begin
            nxt = P_WAIT; m_snoozes = 0;
          end else if (snz) begin
            if (limit_on != 0 && m_snoozes == MAX_SNOOZE) begin
              nxt = P_WAIT; m_snoozes = 0;
            end else begin
              nxt = P_SNOOZED; m_snoozes++;
              m_snz_tod = (tod + SNOOZE_MIN) % 1440;
            end
          end else if (m_secs_rung == RING_TIMEOUT_S) begin
            nxt = P_WAIT; m_snoozes = 0;
          end else if (sec_chg) begin
            m_secs_rung++;
          end
        end
        default: begin
          if (ack) begin nxt = P_WAIT; m_snoozes = 0; end
          else if (zero && tod == m_snz_tod) begin nxt = P_RING; m_secs_rung = 0; end
        end
      endcase
    end
    if (p_valid != 0 && p_type == 4 && (p_data >> 5) <= 23) m_ah = p_data >> 5;
    if (p_valid != 0 && p_type == 1 && (p_data >> 4) <= 59) m_am = p_data >> 4;
    m_phase    = nxt;
    m_prev_sec = int'(ss);
    p_valid    = int'(cmd_valid);
    p_type     = int'(cmd_type);
    p_data     = int'(cmd_data);
  endtask

  task automatic step_cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, "_alarm"}, int'(alarm), int'(m_phase == P_RING));
    check({tag, "_armed"}, int'(armed), int'(m_phase != P_OFF));
    check({tag, "_ahr"}, int'(ahr), m_ah);
    check({tag, "_amin"}, int'(amin), m_am);
  endtask

  task automatic set_tod(input int tod, input int s, input int msec);
    hh = 5'(tod / 60); mm = 6'(tod % 60); ss = 6'(s); ms = 10'(msec);
  endtask

  task automatic send_cmd(input int t, input int d);
    cmd_valid = 1'b1; cmd_type = 3'(t); cmd_data = 10'(d);
    step_cycle("cmd");
    cmd_valid = 1'b0;
  endtask

  initial begin
    int t, r, exp_after;
`ifdef RTC_ALARM_SNOOZE_LIMIT_EN
    limit_on = 1; exp_after = 0;
`else
    limit_on = 0; exp_after = 1;
`endif
    cmd_valid = 0; cmd_type = 0; cmd_data = 0; ack = 0; snz = 0;
    set_tod(0, 0, 0);
    arst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_alarm", int'(alarm), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_ahr", int'(ahr), 0);
    check("rst_amin", int'(amin), 0);
    arst = 1'b0;

    send_cmd(4, 7 << 5); send_cmd(1, 30 << 4); send_cmd(0, 1); step_cycle("idle");
    check("set_0730_h", int'(ahr), 7);
    check("set_0730_m", int'(amin), 30);
    check("armed_after_arm", int'(armed), 1);
    set_tod(7 * 60 + 29, 59, 999); step_cycle("pre");
    check("pre_match_quiet", int'(alarm), 0);
    set_tod(7 * 60 + 30, 0, 0); step_cycle("match");
    check("ring_after_match", int'(alarm), 1);
    check("armed_while_ring", int'(armed), 1);

    for (int s = 1; s <= 60; s++) begin
      set_tod(7 * 60 + 30 + s / 60, s % 60, 500);
      step_cycle("tmo");
    end
    check("ring_at_60th_sec", int'(alarm), 1);
    step_cycle("tmo_end");
    check("timeout_stop", int'(alarm), 0);
    check("timeout_armed", int'(armed), 1);
    set_tod(7 * 60 + 30, 0, 0); step_cycle("rering");
    check("second_pass_rings", int'(alarm), 1);

    set_tod(7 * 60 + 30, 1, 0); ack = 1; snz = 1; step_cycle("ack_snz");
    ack = 0; snz = 0;
    check("ack_wins_alarm", int'(alarm), 0);
    check("ack_wins_armed", int'(armed), 1);
    set_tod(7 * 60 + 35, 0, 0); step_cycle("no_snz");
    check("no_snooze_ring", int'(alarm), 0);

    send_cmd(4, 23 << 5); send_cmd(1, 58 << 4); step_cycle("idle");
    set_tod(23 * 60 + 58, 0, 0); step_cycle("m2358");
    check("ring_2358", int'(alarm), 1);
    set_tod(23 * 60 + 58, 10, 0); snz = 1; step_cycle("snz2358"); snz = 0;
    check("snoozed_quiet", int'(alarm), 0);
    check("snoozed_armed", int'(armed), 1);
    set_tod(2, 59, 999); step_cycle("snzpre");
    check("snz_wrap_pre", int'(alarm), 0);
    set_tod(3, 0, 0); step_cycle("snzhit");
    check("snz_wrap_ring", int'(alarm), 1);
    ack = 1; step_cycle("ack"); ack = 0;

    send_cmd(4, 25 << 5); send_cmd(1, 60 << 4); step_cycle("idle");
    check("oor_hours_kept", int'(ahr), 23);
    check("oor_min_kept", int'(amin), 58);

    set_tod(23 * 60 + 58, 0, 0); step_cycle("ring3");
    set_tod(23 * 60 + 58, 5, 0); snz = 1; step_cycle("snz3"); snz = 0;
    send_cmd(0, 0); step_cycle("idle");
    check("disarm_snz", int'(armed), 0);
    set_tod(3, 0, 0); step_cycle("dis_target");
    check("disarm_no_ring", int'(alarm), 0);

    send_cmd(0, 1); step_cycle("idle");
    t = 23 * 60 + 58;
    set_tod(t, 0, 0); step_cycle("lim_ring");
    for (int k = 0; k < 4; k++) begin
      set_tod(t, 30, 0); snz = 1; step_cycle("lim_snz"); snz = 0;
      if (k < 3) begin
        t = (t + SNOOZE_MIN) % 1440;
        set_tod(t, 0, 0); step_cycle("lim_hit");
        check("snooze_rering", int'(alarm), 1);
      end
    end
    check("fourth_snooze_quiet", int'(alarm), 0);
    t = (t + SNOOZE_MIN) % 1440;
    set_tod(t, 0, 0); step_cycle("lim_after");
    check("after_fourth_target", int'(alarm), exp_after);
    ack = 1; step_cycle("ack"); ack = 0;

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      t = m_ah * 60 + m_am;
      else if (r < 6) t = m_snz_tod;
      else            t = $urandom_range(0, 1439);
      set_tod(t, ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 59),
              ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 999));
      ack = ($urandom_range(0, 63) == 0);
      snz = ($urandom_range(0, 31) == 0);
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_type  = 3'($urandom_range(0, 7));
      cmd_data  = 10'($urandom_range(0, 1023));
      if (cmd_type == 3'd0 && $urandom_range(0, 3) != 0) cmd_data[0] = 1'b1;
      step_cycle("rnd");
    end
    cmd_valid = 0; ack = 0; snz = 0;

    send_cmd(0, 0); send_cmd(0, 1); send_cmd(4, 5 << 5); send_cmd(1, 10 << 4); step_cycle("idle");
    set_tod(5 * 60 + 10, 0, 0); step_cycle("rst_ring");
    check("ring_before_rst", int'(alarm), 1);
    #2 arst = 1'b1;
    #1;
    check("async_rst_alarm", int'(alarm), 0);
    check("async_rst_armed", int'(armed), 0);
    check("async_rst_ahr", int'(ahr), 0);
    check("async_rst_amin", int'(amin), 0);
    model_reset();
    @(posedge clk);
    #1 arst = 1'b0;
    repeat (3) step_cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_alarm.md
Name: rtc_alarm

Overview:
- Daily alarm stage that sits directly downstream of the RTC clock and shares its command bus.
- Takes the running hours/minutes/seconds/milliseconds from the RTC and holds a programmable alarm time (HH:MM).
- Raises a ringing output when the time matches, with acknowledge, snooze and ring-timeout handling.
- Uses command codes that the RTC ignores, so both blocks sit on one cmd bus.

Parameters:
- RING_TIMEOUT_S, 60, seconds of unattended ringing before auto-stop (1..255).
- SNOOZE_MIN, 5, minutes added to the current time on snooze (1..59).
- MAX_SNOOZE, 3, snooze limit; used only with the optional feature (1..15).

Ports:
- clk_i  in  1  system clock; the RTC advances 1 ms per cycle.
- arst_i  in  1  reset: asynchronous, active-high.
- cmd_valid_i  in  1  command strobe, shared with the RTC.
- cmd_type_i  in  3  command code.
- cmd_data_i  in  10  command payload.
- hours_i  in  5  current hours from the RTC, 0..23.
- minutes_i  in  6  current minutes, 0..59.
- seconds_i  in  6  current seconds, 0..59.
- milliseconds_i  in  10  current milliseconds, 0..999.
- ack_i  in  1  user stop, level-sampled each cycle.
- snooze_i  in  1  user snooze, level-sampled each cycle.
- alarm_o  out  1  ringing indication.
- armed_o  out  1  alarm enabled (any state other than IDLE).
- alarm_hours_o  out  5  programmed alarm hour.
- alarm_minutes_o  out  6  programmed alarm minute.

Behaviour:
- Reset (arst_i high, any time): state IDLE; alarm_o=0, armed_o=0, alarm_hours_o=0, alarm_minutes_o=0; timeout and snooze counters 0.
- Commands are acted on the cycle after cmd_valid_i is sampled (registered, 1-cycle latency):
  - 3'b100 SET_ALARM_HOURS: value = cmd_data_i[9:5].
  - 3'b001 SET_ALARM_MINUTES: value = cmd_data_i[9:4].
  - 3'b000 ALARM_CTRL: cmd_data_i[0]=1 arms, 0 disarms.
  - All other codes are ignored (they belong to the RTC).
- Out-of-range set values (hours>23, minutes>59) are dropped; the register keeps its old value. No modulo.
- Match condition: hours_i/minutes_i equal the target, seconds_i==0 and milliseconds_i==0. This is a single-cycle event.
- FSM states: IDLE, ARMED, RINGING, SNOOZE.
  - IDLE -> ARMED on ALARM_CTRL arm.
  - ARMED -> RINGING on match with the alarm time.
  - RINGING -> ARMED on ack_i, or when the timeout counter reaches RING_TIMEOUT_S.
  - RINGING -> SNOOZE on snooze_i. Snooze target = current HH:MM + SNOOZE_MIN, with minute wrap 59->0 carrying into hours and 23->0.
  - SNOOZE -> RINGING on match with the snooze target.
  - SNOOZE -> ARMED on ack_i (cancels snooze).
  - Disarm command: -> IDLE from any state.
- alarm_o is registered: high exactly while the state is RINGING, asserting the cycle after the match.
- Timeout counter:
  - Cleared on entering RINGING.
  - Increments on each cycle where seconds_i differs from its value one cycle earlier (edge detect on the seconds field).
- Priority, highest first: arst_i, disarm, ack_i, snooze_i, timeout, match.
- Setting the alarm time while in RINGING or SNOOZE updates the registers only; the active ring or snooze target is unaffected.
- A match while already RINGING has no effect. An alarm time equal to the snooze target has no special effect.

Optional Feature:
- Macro: RTC_ALARM_SNOOZE_LIMIT_EN.
- Defined:
  - A 4-bit snooze counter increments on each RINGING->SNOOZE transition.
  - Once it equals MAX_SNOOZE, snooze_i in RINGING is treated as ack_i.
  - The counter clears on ack, timeout, disarm and reset.
- Undefined: unlimited snoozes; no counter is synthesised.

Decomposition:
- Package rtc_pkg holds:
  - Command code localparams for all commands, RTC and alarm.
  - Field widths (HOURS_W=5, MIN_W=6, SEC_W=6, MS_W=10).
  - The alarm state enum.
- One natural sub-module: rtc_time_add_min, a combinational HH:MM + N minutes adder with hour/day wrap, reused for the snooze target.

Test Plan:
- Set alarm 07:30, arm, drive time 07:29:59.999 -> 07:30:00.000: alarm_o rises one cycle after the match; armed_o=1 throughout.
- Ringing, no input, seconds advance 60 times -> alarm_o falls; state ARMED; a second pass through 07:30:00.000 rings again.
- Alarm 23:58, snooze with SNOOZE_MIN=5 at 23:58:10 -> alarm_o=0; time 00:03:00.000 -> alarm_o=1.
- SET_ALARM_HOURS data[9:5]=25 and SET_ALARM_MINUTES data[9:4]=60 -> alarm_hours_o/alarm_minutes_o unchanged.
- ack_i and snooze_i high together while ringing -> state ARMED, no snooze. Disarm command mid-SNOOZE -> armed_o=0, no ring at the target.
- With RTC_ALARM_SNOOZE_LIMIT_EN and MAX_SNOOZE=3: the fourth snooze_i acts as ack -> ARMED. Assert arst_i mid-RINGING -> all outputs 0 immediately.
